// File: rtl/uc_atualiza_quadro.sv
// uc_atualiza_quadro: frame-update control unit; pauses rendering and walks all object slots on each frame tick
module uc_atualiza_quadro #(
  parameter int N_SLOTS = 8,
  parameter int ADDR_W  = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              iniciar,
  input  logic              fim_quadro,
  input  logic              slot_valido,
  input  logic              atualiza_pronto,
  output logic              pausar_renderizacao,
  output logic [ADDR_W-1:0] endereco_slot,
  output logic              le_slot,
  output logic              atualiza_slot,
  output logic              escreve_slot,
  output logic              quadro_concluido,
  output logic [7:0]        quadros_perdidos,
  output logic [3:0]        db_estado
);
  typedef enum logic [3:0] {
    inicial         = 4'h0,
    espera_quadro   = 4'h1,
    pausa           = 4'h2,
    le              = 4'h3,
    decide          = 4'h4,
    atualiza        = 4'h5,
    espera_atualiza = 4'h6,
    escreve         = 4'h7,
    proximo         = 4'h8,
    conclui         = 4'h9,
    erro            = 4'hF
  } estado_t;
  localparam logic [ADDR_W-1:0] last_slot = ADDR_W'(N_SLOTS - 1);
  estado_t state, state_next;
  logic    at_last, perdido;
  assign at_last = endereco_slot == last_slot;
  // a tick is only a missed frame when the unit is enabled but not idle-waiting for it
  assign perdido = fim_quadro && state != espera_quadro && !(state == inicial && !iniciar);
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state            <= inicial;
      endereco_slot    <= '0;
      quadros_perdidos <= '0;
    end else begin
      state <= state_next;
      if (state == pausa)
        endereco_slot <= '0;
      else if (state == proximo && !at_last)
        endereco_slot <= endereco_slot + 1'b1;
      if (perdido && quadros_perdidos != 8'hff)
        quadros_perdidos <= quadros_perdidos + 1'b1;
    end
  always_comb begin
    state_next = state;
    case (state)
      inicial:         state_next = iniciar ? espera_quadro : inicial;
      espera_quadro:   state_next = !iniciar ? inicial : fim_quadro ? pausa : espera_quadro;
      pausa:           state_next = le;
      le:              state_next = decide;
      decide:          state_next = slot_valido ? atualiza : proximo;
      atualiza:        state_next = espera_atualiza;
      espera_atualiza: state_next = atualiza_pronto ? escreve : espera_atualiza;
      escreve:         state_next = proximo;
      proximo:         state_next = at_last ? conclui : le;
      conclui:         state_next = espera_quadro;
      erro:            state_next = inicial;
      default:         state_next = erro;
    endcase
  end
  assign pausar_renderizacao = state >= pausa && state <= proximo;
  assign le_slot             = state == le;
  assign atualiza_slot       = state == atualiza;
  assign escreve_slot        = state == escreve;
  assign quadro_concluido    = state == conclui;
  assign db_estado           = state;
endmodule

// File: tb/tb_uc_atualiza_quadro.sv
// tb_uc_atualiza_quadro: directed, table-driven self-checking bench for the frame-update control unit
module tb_uc_atualiza_quadro;
  logic       clock = 0, reset = 0, iniciar = 0, fim_quadro = 0, slot_valido, atualiza_pronto = 0;
  logic       pausar_renderizacao, le_slot, atualiza_slot, escreve_slot, quadro_concluido;
  logic [2:0] endereco_slot;
  logic [7:0] quadros_perdidos;
  logic [3:0] db_estado;
  logic [7:0] mask = '0;
  int         cur_w = 1, wcnt = 0;
  logic       hold = 0;
  int         n_chk = 0, n_fail = 0;

  uc_atualiza_quadro #(.N_SLOTS(8), .ADDR_W(3)) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .fim_quadro(fim_quadro),
    .slot_valido(slot_valido), .atualiza_pronto(atualiza_pronto),
    .pausar_renderizacao(pausar_renderizacao), .endereco_slot(endereco_slot),
    .le_slot(le_slot), .atualiza_slot(atualiza_slot), .escreve_slot(escreve_slot),
    .quadro_concluido(quadro_concluido), .quadros_perdidos(quadros_perdidos),
    .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  // slot memory model: occupancy from mask, datapath finishes in the W-th wait cycle
  assign slot_valido = mask[endereco_slot];
  always @(negedge clock)
    if (db_estado == 4'h6) begin
      wcnt = wcnt + 1;
      atualiza_pronto = !hold && wcnt >= cur_w;
    end else begin
      wcnt = 0;
      atualiza_pronto = 0;
    end

  typedef struct {
    logic [7:0] mask;
    int         w;
    int         lat;
    int         n_upd;
  } vec_t;
  vec_t tbl[5];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_state(input logic [3:0] s, input int bound);
    int n = 0;
    while (db_estado !== s && n < bound) begin
      @(posedge clock); #1;
      n++;
    end
    chk($sformatf("reach_state_%0h", s), int'(db_estado), int'(s));
  endtask

  task automatic tick_from_espera();
    @(posedge clock); #1;
    fim_quadro = 1;
    @(posedge clock); #1;
    fim_quadro = 0;
  endtask

  task automatic run_frame(input int idx);
    int n = 0, n_le = 0, n_upd = 0, n_wr = 0;
    logic [7:0] upd_at = '0;
    logic pause_ok = 1, done = 0;
    mask  = tbl[idx].mask;
    cur_w = tbl[idx].w;
    tick_from_espera();
    chk($sformatf("v%0d_pausa", idx), int'(db_estado), 2);
    while (!done && n < 500) begin
      @(posedge clock); #1;
      n++;
      n_le += int'(le_slot);
      n_wr += int'(escreve_slot);
      if (atualiza_slot) begin
        n_upd++;
        upd_at[endereco_slot] = 1'b1;
      end
      if (quadro_concluido) done = 1;
      else if (!pausar_renderizacao) pause_ok = 0;
    end
    chk($sformatf("v%0d_latency", idx), n, tbl[idx].lat);
    chk($sformatf("v%0d_le_count", idx), n_le, 8);
    chk($sformatf("v%0d_upd_count", idx), n_upd, tbl[idx].n_upd);
    chk($sformatf("v%0d_wr_count", idx), n_wr, tbl[idx].n_upd);
    chk($sformatf("v%0d_upd_addr", idx), int'(upd_at), int'(tbl[idx].mask));
    chk($sformatf("v%0d_pause_held", idx), int'(pause_ok), 1);
    chk($sformatf("v%0d_conclui_pausar", idx), int'(pausar_renderizacao), 0);
    chk($sformatf("v%0d_addr_no_wrap", idx), int'(endereco_slot), 7);
  endtask

  initial begin
    tbl[0] = '{8'h00, 1, 25, 0};
    tbl[1] = '{8'h24, 1, 31, 2};
    tbl[2] = '{8'hFF, 1, 49, 8};
    tbl[3] = '{8'h81, 3, 35, 2};
    tbl[4] = '{8'h01, 2, 29, 1};

    repeat (3) @(posedge clock);
    #1 reset = 1;
    @(posedge clock); #1;
    chk("reset_state", int'(db_estado), 0);
    chk("reset_pausar", int'(pausar_renderizacao), 0);
    chk("reset_addr", int'(endereco_slot), 0);
    chk("reset_perdidos", int'(quadros_perdidos), 0);
    fim_quadro = 1;
    @(posedge clock); #1;
    fim_quadro = 0;
    chk("idle_tick_ignored_state", int'(db_estado), 0);
    chk("idle_tick_not_counted", int'(quadros_perdidos), 0);
    iniciar = 1;
    @(posedge clock); #1;
    chk("start_espera", int'(db_estado), 1);

    for (int i = 0; i < 5; i++) run_frame(i);
    chk("no_missed_frames", int'(quadros_perdidos), 0);

    mask = 8'h08; cur_w = 1; hold = 1;
    tick_from_espera();
    wait_state(4'h6, 100);
    repeat (100) @(posedge clock);
    #1;
    chk("stall_state", int'(db_estado), 6);
    chk("stall_pausar", int'(pausar_renderizacao), 1);
    chk("stall_addr", int'(endereco_slot), 3);
    for (int i = 0; i < 300; i++) begin
      @(negedge clock) fim_quadro = 1;
      @(negedge clock) fim_quadro = 0;
    end
    #1;
    chk("perdidos_saturated", int'(quadros_perdidos), 255);
    chk("stall_no_restart", int'(db_estado), 6);

    reset = 0;
    #2;
    chk("async_reset_state", int'(db_estado), 0);
    chk("async_reset_pausar", int'(pausar_renderizacao), 0);
    chk("async_reset_addr", int'(endereco_slot), 0);
    chk("async_reset_perdidos", int'(quadros_perdidos), 0);
    chk("async_reset_strobes", int'({le_slot, atualiza_slot, escreve_slot, quadro_concluido}), 0);
    hold = 0;
    @(negedge clock) reset = 1;
    @(posedge clock); #1;
    chk("after_reset_espera", int'(db_estado), 1);

    mask = 8'h00;
    tick_from_espera();
    wait_state(4'h3, 20);
    iniciar = 0;
    wait_state(4'h9, 100);
    @(posedge clock); #1;
    chk("drop_espera", int'(db_estado), 1);
    @(posedge clock); #1;
    chk("drop_inicial", int'(db_estado), 0);
    fim_quadro = 1;
    @(posedge clock); #1;
    fim_quadro = 0;
    @(posedge clock); #1;
    chk("drop_tick_ignored", int'(db_estado), 0);
    chk("drop_tick_not_counted", int'(quadros_perdidos), 0);

    @(negedge clock);
    iniciar = 1;
    fim_quadro = 1;
    @(posedge clock); #1;
    fim_quadro = 0;
    chk("inicial_tick_state", int'(db_estado), 1);
    chk("inicial_tick_counted", int'(quadros_perdidos), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
